// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer command encodings and controller state type
// Purpose: one-hot ctrl command codes shared by timer and timer_ctrl, plus the
// controller state encoding.
package timer_pkg;

    localparam logic [2:0] CTRL_NONE  = 3'b000;
    localparam logic [2:0] CTRL_START = 3'b001;
    localparam logic [2:0] CTRL_STOP  = 3'b010;
    localparam logic [2:0] CTRL_PAUSE = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// rtl/timer_ctrl_if.sv - button, timer and status bundle of timer_ctrl
// Purpose: groups the controller's button inputs, timer link and status outputs.
// Ports (master = controller view):
//   btn_start/btn_stop/btn_pause in : raw buttons
//   sec, limit                   in : timer seconds value, auto-pause threshold
//   ctrl                         out: one-hot command pulse to timer
//   running, paused, alarm       out: controller status
interface timer_ctrl_if;

    logic        btn_start;
    logic        btn_stop;
    logic        btn_pause;
    logic [15:0] sec;
    logic [15:0] limit;
    logic [2:0]  ctrl;
    logic        running;
    logic        paused;
    logic        alarm;

    modport master (
        input  btn_start, btn_stop, btn_pause, sec, limit,
        output ctrl, running, paused, alarm
    );

    modport slave (
        output btn_start, btn_stop, btn_pause, sec, limit,
        input  ctrl, running, paused, alarm
    );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchroniser, debounce counter and press detector
// Purpose: turns one raw asynchronous button into a clean level and a
// one-cycle press pulse on each debounced 0->1 transition.
// Ports:
//   clk, rst  in : clock, synchronous active-high reset
//   btn_raw   in : raw bouncy button
//   level     out: debounced level
//   press     out: one-cycle pulse, registered, on debounced rising edge
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int DB_CNT_W        = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                level_prev_q, level_prev_d;
    logic                press_q, press_d;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        // Counter only runs while the synchronised input disagrees with the
        // debounced level; any agreement restarts the stability window.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DB_CNT_W'(1);
        end
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - button-driven command sequencer for the timer block
// Purpose: debounces start/stop/pause buttons, arbitrates them with the
// limit-hit condition and issues single-cycle one-hot commands to timer.
// Ports:
//   clk, rst  in : clock shared with timer, synchronous active-high reset
//   bus       master modport of timer_ctrl_if (buttons, sec, limit in;
//             ctrl, running, paused, alarm out)
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int DB_CNT_W        = 20
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.master bus
);

    logic press_start, press_stop, press_pause;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db_start (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_start), .level(), .press(press_start)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db_stop (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_stop), .level(), .press(press_stop)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db_pause (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_pause), .level(), .press(press_pause)
    );

    ctrl_state_e state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        limit_hit;

    assign limit_hit = (state_q == RUN) && (bus.limit != 16'd0) && (bus.sec >= bus.limit);

    // Priority: stop > limit-hit > pause > start. Losing events are dropped.
    always_comb begin
        state_d = state_q;
        ctrl_d  = CTRL_NONE;
        if (press_stop) begin
            state_d = IDLE;
            ctrl_d  = CTRL_STOP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_start) begin
                        state_d = RUN;
                        ctrl_d  = CTRL_START;
                    end
                end
                RUN: begin
                    if (limit_hit) begin
                        state_d = DONE;
                        ctrl_d  = CTRL_PAUSE;
                    end else if (press_pause) begin
                        state_d = PAUSE;
                        ctrl_d  = CTRL_PAUSE;
                    end
                end
                PAUSE: begin
                    if (press_pause || press_start) begin
                        state_d = RUN;
                        ctrl_d  = CTRL_START;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Reset drives STOP so the un-reset timer clears its seconds count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= CTRL_STOP;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.ctrl    = ctrl_q;
    assign bus.running = (state_q == RUN);
    assign bus.paused  = (state_q == PAUSE) || (state_q == DONE);
    assign bus.alarm   = (state_q == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl
module tb_timer_ctrl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    timer_ctrl_if bus ();

    timer_ctrl #(.DEBOUNCE_CYCLES(D), .DB_CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Reference model. States: 0 idle, 1 run, 2 pause, 3 done.
    // Buttons: 0 start, 1 stop, 2 pause.
    int         m_state;
    logic [2:0] m_ctrl;
    logic [D-1:0] m_win [3];
    bit         m_lvl [3];
    int         m_pend [3];

    logic [5:0] dut_out;
    assign dut_out = {bus.ctrl, bus.running, bus.paused, bus.alarm};

    function automatic logic [5:0] model_out();
        return {m_ctrl, m_state == 1, m_state >= 2, m_state == 3};
    endfunction

    // One clock edge; the model consumes the inputs present before the edge.
    // A button press reaches the command logic 4 edges after the edge that
    // took its D-th consecutive high sample.
    task automatic tick();
        bit          r_rst;
        bit          raw [3];
        logic [15:0] s, l;
        bit          p [3];
        bit          hit;
        r_rst  = rst;
        raw[0] = bus.btn_start;
        raw[1] = bus.btn_stop;
        raw[2] = bus.btn_pause;
        s      = bus.sec;
        l      = bus.limit;
        @(posedge clk);
        if (r_rst) begin
            for (int i = 0; i < 3; i++) begin
                m_win[i]  = '0;
                m_lvl[i]  = 1'b0;
                m_pend[i] = -1;
            end
            m_state = 0;
            m_ctrl  = 3'b010;
        end else begin
            for (int i = 0; i < 3; i++) begin
                p[i] = 1'b0;
                if (m_pend[i] > 0) begin
                    m_pend[i]--;
                    if (m_pend[i] == 0) begin
                        p[i]      = 1'b1;
                        m_pend[i] = -1;
                    end
                end
            end
            hit    = (m_state == 1) && (l != 0) && (s >= l);
            m_ctrl = 3'b000;
            if (p[1]) begin
                m_ctrl = 3'b010; m_state = 0;
            end else if (hit) begin
                m_ctrl = 3'b100; m_state = 3;
            end else if (m_state == 1 && p[2]) begin
                m_ctrl = 3'b100; m_state = 2;
            end else if ((m_state == 0 && p[0]) || (m_state == 2 && (p[0] || p[2]))) begin
                m_ctrl = 3'b001; m_state = 1;
            end
            for (int i = 0; i < 3; i++) begin
                m_win[i] = {m_win[i][D-2:0], raw[i]};
                if (m_win[i] == '1 && !m_lvl[i]) begin
                    m_lvl[i]  = 1'b1;
                    m_pend[i] = 4;
                end else if (m_win[i] == '0 && m_lvl[i]) begin
                    m_lvl[i] = 1'b0;
                end
            end
        end
        #1;
    endtask

    // Holds a button mask, releases it, and tallies DUT pulses and
    // cycles where the DUT differs from the model.
    task automatic hold_buttons(input logic [2:0] mask, input int hold, input int settle,
                                output int c_st, output int c_sp, output int c_pa,
                                output int n_mis);
        c_st = 0; c_sp = 0; c_pa = 0; n_mis = 0;
        bus.btn_start = mask[0];
        bus.btn_stop  = mask[1];
        bus.btn_pause = mask[2];
        for (int i = 0; i < hold + settle; i++) begin
            if (i == hold) begin
                bus.btn_start = 1'b0;
                bus.btn_stop  = 1'b0;
                bus.btn_pause = 1'b0;
            end
            tick();
            case (bus.ctrl)
                3'b001:  c_st++;
                3'b010:  c_sp++;
                3'b100:  c_pa++;
                default: ;
            endcase
            if (dut_out !== model_out()) n_mis++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (dut_out !== 6'b010_000) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b want 010000", i, dut_out);
            end
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (dut_out !== 6'b000_000 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 000000", dut_out);
        end
    endtask

    task automatic test_debounce();
        int len;
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, D - 1);
            bus.btn_start = 1'b1;
            for (int i = 0; i < len; i++) begin
                tick();
                n_tests++;
                if (bus.ctrl !== 3'b000 || dut_out !== model_out()) begin
                    n_fail++;
                    $display("FAIL debounce_glitch: got %b want %b (ctrl 000)", dut_out, model_out());
                end
            end
            bus.btn_start = 1'b0;
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) tick();
        end
        for (int i = 0; i < 6; i++) tick();
        bus.btn_start = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            n_tests++;
            if (bus.ctrl !== (e == 8 ? 3'b001 : 3'b000) || bus.running !== (e >= 8)
                || dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL debounce_latency edge %0d: ctrl=%b running=%b want ctrl=%b running=%b",
                         e, bus.ctrl, bus.running, (e == 8 ? 3'b001 : 3'b000), (e >= 8));
            end
        end
        bus.btn_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_pause_resume();
        int cs, cp, ca, nm;
        hold_buttons(3'b100, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || ca !== 1 || cs !== 0 || cp !== 0 || bus.paused !== 1'b1 || bus.running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause: pulses s/p/pa=%0d/%0d/%0d mis=%0d paused=%b want 0/0/1 0 1", cs, cp, ca, nm, bus.paused);
        end
        hold_buttons(3'b100, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || cs !== 1 || ca !== 0 || cp !== 0 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL resume: pulses s/p/pa=%0d/%0d/%0d mis=%0d running=%b want 1/0/0 0 1", cs, cp, ca, nm, bus.running);
        end
        hold_buttons(3'b001, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || cs !== 0 || ca !== 0 || cp !== 0 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_run: pulses s/p/pa=%0d/%0d/%0d mis=%0d want 0/0/0 0", cs, cp, ca, nm);
        end
    endtask

    task automatic test_simultaneous();
        int cs, cp, ca, nm;
        hold_buttons(3'b111, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || cp !== 1 || cs !== 0 || ca !== 0 || dut_out !== 6'b000_000) begin
            n_fail++;
            $display("FAIL simul_all: pulses s/p/pa=%0d/%0d/%0d mis=%0d out=%b want 0/1/0 0 000000", cs, cp, ca, nm, dut_out);
        end
        hold_buttons(3'b001, 6, 10, cs, cp, ca, nm);
        hold_buttons(3'b100, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || bus.paused !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_setup: mis=%0d paused=%b want 0 1", nm, bus.paused);
        end
        hold_buttons(3'b101, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || cs !== 1 || ca !== 0 || cp !== 0 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_start_pause: pulses s/p/pa=%0d/%0d/%0d mis=%0d want 1/0/0 0", cs, cp, ca, nm);
        end
    endtask

    task automatic test_limit();
        int cs, cp, ca, nm;
        bus.limit = 16'd5;
        bus.sec   = 16'd4;
        tick();
        tick();
        n_tests++;
        if (bus.ctrl !== 3'b000 || bus.running !== 1'b1 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL limit_below: got %b want 000100", dut_out);
        end
        bus.sec = 16'd5;
        tick();
        n_tests++;
        if (dut_out !== 6'b100_011 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL limit_hit: got %b want 100011", dut_out);
        end
        hold_buttons(3'b101, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || cs !== 0 || ca !== 0 || cp !== 0 || bus.alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ignore: pulses s/p/pa=%0d/%0d/%0d mis=%0d alarm=%b want 0/0/0 0 1", cs, cp, ca, nm, bus.alarm);
        end
        hold_buttons(3'b010, 6, 10, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || cp !== 1 || dut_out !== 6'b000_000) begin
            n_fail++;
            $display("FAIL done_stop: stop pulses=%0d mis=%0d out=%b want 1 0 000000", cp, nm, dut_out);
        end
        bus.limit = 16'd0;
        bus.sec   = 16'd65535;
        hold_buttons(3'b001, 6, 14, cs, cp, ca, nm);
        n_tests++;
        if (nm !== 0 || cs !== 1 || ca !== 0 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_zero: pulses s/pa=%0d/%0d mis=%0d running=%b want 1/0 0 1", cs, ca, nm, bus.running);
        end
        bus.sec   = 16'd100;
        bus.limit = 16'd50;
        tick();
        n_tests++;
        if (dut_out !== 6'b100_011 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL limit_lowered: got %b want 100011", dut_out);
        end
        hold_buttons(3'b010, 6, 10, cs, cp, ca, nm);
        bus.limit = 16'd0;
        bus.sec   = 16'd0;
    endtask

    task automatic test_reset_mid();
        int cs, cp, ca, nm;
        bus.btn_stop = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (dut_out !== 6'b010_000) begin
            n_fail++;
            $display("FAIL reset_mid_assert: got %b want 010000", dut_out);
        end
        rst = 1'b0;
        bus.btn_stop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_tests++;
            if (dut_out !== 6'b000_000 || dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL reset_mid_no_press cyc %0d: got %b want 000000", i, dut_out);
            end
        end
        hold_buttons(3'b001, 6, 10, cs, cp, ca, nm);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (dut_out !== 6'b010_000) begin
            n_fail++;
            $display("FAIL reset_in_run: got %b want 010000 (running was %0d pulses)", dut_out, cs);
        end
        tick();
        n_tests++;
        if (dut_out !== 6'b000_000 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL reset_in_run_release: got %b want 000000", dut_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) bus.btn_start = ~bus.btn_start;
            if ($urandom_range(0, 15) == 0) bus.btn_stop = ~bus.btn_stop;
            if ($urandom_range(0, 7) == 0) bus.btn_pause = ~bus.btn_pause;
            if ($urandom_range(0, 3) == 0) bus.sec = bus.sec + 16'd1;
            if ($urandom_range(0, 40) == 0) bus.sec = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 60) == 0)
                bus.limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            rst = ($urandom_range(0, 199) == 0);
            tick();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", c, dut_out, model_out());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_stop  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.sec       = 16'd0;
        bus.limit     = 16'd0;
        m_state       = 0;
        m_ctrl        = 3'b010;
        for (int i = 0; i < 3; i++) begin
            m_win[i]  = '0;
            m_lvl[i]  = 1'b0;
            m_pend[i] = -1;
        end
        test_reset();
        test_debounce();
        test_pause_resume();
        test_simultaneous();
        test_limit();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Command sequencer in front of the `timer` seconds counter.
- Takes three raw push buttons (start, stop, pause) and synchronises and debounces them.
- Resolves simultaneous presses and tracks the run state.
- Drives the timer's one-hot `ctrl[2:0]` bus with single-cycle command pulses.
- Watches the timer's `sec` output against a programmable limit and auto-pauses with an alarm when the limit is reached.

Parameters:
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); must be >= 2.
- DB_CNT_W, 20, width of each debounce counter; must satisfy 2^DB_CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, same clock as `timer`.
- rst  in  1  synchronous reset, active-high.
- btn_start  in  1  raw start button; asynchronous, bouncy.
- btn_stop  in  1  raw stop button; asynchronous, bouncy.
- btn_pause  in  1  raw pause/resume button; asynchronous, bouncy.
- sec  in  16  current seconds value from `timer`.
- limit  in  16  auto-pause threshold in seconds; 0 disables it; quasi-static.
- ctrl  out  3  to `timer`: 001 = start, 010 = stop, 100 = pause, 000 = hold.
- running  out  1  high in state RUN.
- paused  out  1  high in state PAUSE or DONE.
- alarm  out  1  high in state DONE.

Behaviour:
Clock and reset:
- One clock, `clk`. Reset `rst` is synchronous and active-high. All registers are updated on the `clk` rising edge.
- Reset values: ctrl = 3'b010, running = 0, paused = 0, alarm = 0, state = IDLE, all sync/debounce registers and counters = 0.
- The 010 reset value forces the un-reset `timer` into STOP, clearing `sec`. On the first cycle after `rst` falls, ctrl = 000 unless a command is issued.
- Reset asserted mid-operation (including mid-debounce) discards pending presses; the same reset values apply.

Input path, per button:
- Two-flop synchroniser feeds a debounce counter.
- The counter clears whenever the synchronised value equals the debounced level.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
- A "press" is a one-cycle pulse on a 0->1 transition of the debounced level. Releases generate nothing.
- Latency: a button held high from the edge it is first sampled produces its ctrl pulse on exactly DEBOUNCE_CYCLES+3 edges later. Glitches shorter than DEBOUNCE_CYCLES cycles produce nothing.

Command arbitration:
- Same-cycle presses resolve with priority stop > pause > start. Losing presses are dropped, not queued.
- Limit-hit condition: state == RUN, limit != 0, sec >= limit (unsigned compare).
- Priority: stop press > limit-hit > pause press > start press.

State machine (states IDLE, RUN, PAUSE, DONE; transitions shown as condition -> ctrl pulse, next state):
- IDLE: start -> 001, RUN. Stop -> 010, IDLE. Pause is ignored.
- RUN: stop -> 010, IDLE. Limit-hit -> 100, DONE. Pause -> 100, PAUSE. Start is ignored.
- PAUSE: stop -> 010, IDLE. Pause (resume) or start -> 001, RUN.
- DONE: stop -> 010, IDLE. Start and pause are ignored. `alarm` stays high until stop.

ctrl pulse rules:
- ctrl is registered and one-hot, high for exactly one cycle, issued on the cycle after the press or limit-hit is detected.
- Status outputs change on the same edge as the ctrl pulse.
- At most one command per cycle; ctrl is never multi-hot.

Limit behaviour:
- Limit-hit is re-evaluated only in RUN.
- If `limit` is changed to a value <= sec while RUN, the hit fires on the next cycle.
- `sec` wrap-around (65535 -> 0) needs no special handling.

Decomposition:
- Package `timer_pkg` holds:
  - CTRL_START = 3'b001, CTRL_STOP = 3'b010, CTRL_PAUSE = 3'b100, CTRL_NONE = 3'b000. These are shared with `timer`.
  - Controller state encodings IDLE/RUN/PAUSE/DONE (2-bit).
- Sub-module `btn_debounce` (parameters DEBOUNCE_CYCLES, DB_CNT_W; ports clk, rst, btn_raw, level, press) contains synchroniser, debounce counter and edge detector. It is instantiated three times.
- Arbitration and FSM stay in `timer_ctrl`.

Test Plan:
All tests use DEBOUNCE_CYCLES = 4.
1. Reset: hold rst for 3 cycles -> ctrl = 010 during reset, 000 on the first cycle after; running = paused = alarm = 0.
2. Debounce: btn_start toggles with 1–3 cycle pulses -> ctrl stays 000. Then btn_start held high -> exactly one ctrl = 001 pulse 7 edges after the first sample, running = 1; holding longer issues nothing more.
3. Pause/resume: from RUN, press pause -> single 100, paused = 1. Press pause again -> single 001, running = 1. Press start while RUN -> ctrl stays 000.
4. Simultaneous presses: start + stop + pause debounced in the same cycle from RUN -> only 010, state IDLE. Start + pause from PAUSE -> 001.
5. Limit: limit = 5, RUN, drive sec 4 -> 5 -> next cycle ctrl = 100, alarm = 1, paused = 1. Start/pause presses are ignored. Stop -> 010, alarm = 0, IDLE. With limit = 0 and sec = 65535 -> no auto-pause.
6. Reset mid-debounce: btn_stop high for 2 cycles, rst for 1 cycle, release -> no 010 pulse from the button beyond the reset value. With rst asserted in RUN -> ctrl = 010, state IDLE.
